// File: rtl/input_fetch_pkg.sv
// Shared types and constants for the input-tile fetch path.
// The tile type is shared with the data controller.
package input_fetch_pkg;

    localparam int DATA_W     = 16;
    localparam int COORD_W    = 16;
    localparam int MEM_AW     = 14;
    localparam int TILE_DIM   = 6;
    localparam int TILE_SLOTS = 72;
    localparam int SLOT_W     = 7;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        FETCH,
        DRAIN,
        DONE,
        WAIT
    } fetch_state_t;

    typedef logic signed [DATA_W-1:0] elem_t;
    typedef elem_t [TILE_DIM-1:0][TILE_DIM-1:0] tile_t;

endpackage

// File: rtl/input_tile_fetch_addr_gen.sv
// Slot sequencer for the two-tile walk: counters, row base and bound check.
// Row base is x*length from a registered multiply, then +length per row.
module tile_addr_gen
    import input_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              run,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COORD_W-1:0] x2,
    input  logic [COORD_W-1:0] y2,
    input  logic [COORD_W-1:0] length,
    input  logic [COORD_W-1:0] width,
    input  logic [MEM_AW-1:0]  base,
    output logic [MEM_AW-1:0]  mem_addr_o,
    output logic              mem_ren_o,
    output logic              pad,
    output logic [SLOT_W-1:0] slot,
    output logic              last
);

    logic [SLOT_W-1:0]  slot_q;
    logic [2:0]         r_q;
    logic [2:0]         c_q;
    logic               tile_q;
    logic [MEM_AW-1:0]  row_base_q;

    logic [COORD_W-1:0] x_cur;
    logic [COORD_W-1:0] y_cur;
    logic [COORD_W-1:0] mul_x;
    logic [MEM_AW-1:0]  prod;
    logic [COORD_W:0]   xr;
    logic [COORD_W:0]   yc;

    always_comb begin
        x_cur = tile_q ? x2 : x1;
        y_cur = tile_q ? y2 : y1;
        mul_x = run ? x2 : x1;
        prod  = MEM_AW'(mul_x * length);
        xr    = {1'b0, x_cur} + {{(COORD_W-2){1'b0}}, r_q};
        yc    = {1'b0, y_cur} + {{(COORD_W-2){1'b0}}, c_q};
        pad   = (xr >= {1'b0, width}) || (yc >= {1'b0, length});
        slot  = slot_q;
        last  = run && (slot_q == SLOT_W'(TILE_SLOTS-1));
        mem_ren_o  = run && !pad;
        mem_addr_o = '0;
        if (run)
            mem_addr_o = base + row_base_q + y_cur[MEM_AW-1:0]
                       + {{(MEM_AW-3){1'b0}}, c_q};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q     <= '0;
            r_q        <= '0;
            c_q        <= '0;
            tile_q     <= 1'b0;
            row_base_q <= '0;
        end else if (start) begin
            slot_q     <= '0;
            r_q        <= '0;
            c_q        <= '0;
            tile_q     <= 1'b0;
            row_base_q <= prod;
        end else if (run) begin
            slot_q <= slot_q + 1'b1;
            if (c_q == 3'd5) begin
                c_q <= '0;
                // last slot of tile 1 reloads the base for tile 2
                if (slot_q == SLOT_W'(TILE_SLOTS/2 - 1)) begin
                    tile_q     <= 1'b1;
                    r_q        <= '0;
                    row_base_q <= prod;
                end else begin
                    r_q        <= r_q + 1'b1;
                    row_base_q <= row_base_q + length[MEM_AW-1:0];
                end
            end else begin
                c_q <= c_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/input_tile_fetch.sv
// Memory-side responder: fetches two 6x6 tiles (zero padded) per request
// and returns both with a one-cycle valid pulse.
module input_tile_fetch
    import input_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_wen_i,
    input  logic [COORD_W-1:0] fmap_length_i,
    input  logic [COORD_W-1:0] fmap_width_i,
    input  logic [MEM_AW-1:0]  fmap_base_i,
    input  logic [COORD_W-1:0] input_addr_x_i_1,
    input  logic [COORD_W-1:0] input_addr_y_i_1,
    input  logic [COORD_W-1:0] input_addr_x_i_2,
    input  logic [COORD_W-1:0] input_addr_y_i_2,
    input  logic               input_request_i,
    output tile_t              input_data_o_1,
    output tile_t              input_data_o_2,
    output logic               input_valid_o,
    output logic               busy_o,
    output logic [MEM_AW-1:0]  mem_addr_o,
    output logic               mem_ren_o,
    input  elem_t              mem_rdata_i
);

    fetch_state_t state_q;
    fetch_state_t state_n;

    logic [COORD_W-1:0] cfg_len_q;
    logic [COORD_W-1:0] cfg_wid_q;
    logic [MEM_AW-1:0]  cfg_base_q;
    logic [COORD_W-1:0] len_q;
    logic [COORD_W-1:0] wid_q;
    logic [MEM_AW-1:0]  base_q;
    logic [COORD_W-1:0] x1_q;
    logic [COORD_W-1:0] y1_q;
    logic [COORD_W-1:0] x2_q;
    logic [COORD_W-1:0] y2_q;

    logic              start;
    logic              run;
    logic              pad;
    logic              last;
    logic [SLOT_W-1:0] slot;

    logic              rd_vld_q;
    logic              rd_pad_q;
    logic [SLOT_W-1:0] rd_slot_q;

    elem_t stage_q [TILE_SLOTS];
    elem_t stage_n [TILE_SLOTS];

    tile_addr_gen u_addr (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .run        (run),
        .x1         (x1_q),
        .y1         (y1_q),
        .x2         (x2_q),
        .y2         (y2_q),
        .length     (len_q),
        .width      (wid_q),
        .base       (base_q),
        .mem_addr_o (mem_addr_o),
        .mem_ren_o  (mem_ren_o),
        .pad        (pad),
        .slot       (slot),
        .last       (last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE:    if (input_request_i) state_n = LATCH;
            LATCH:   state_n = FETCH;
            FETCH:   if (last) state_n = DRAIN;
            DRAIN:   state_n = DONE;
            DONE:    state_n = WAIT;
            WAIT:    if (!input_request_i) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        input_valid_o = (state_q == DONE);
        busy_o        = (state_q != IDLE);
        start         = (state_q == LATCH);
        run           = (state_q == FETCH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_len_q  <= '0;
            cfg_wid_q  <= '0;
            cfg_base_q <= '0;
        end else if (cfg_wen_i) begin
            cfg_len_q  <= fmap_length_i;
            cfg_wid_q  <= fmap_width_i;
            cfg_base_q <= fmap_base_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_q  <= '0;
            wid_q  <= '0;
            base_q <= '0;
            x1_q   <= '0;
            y1_q   <= '0;
            x2_q   <= '0;
            y2_q   <= '0;
        end else if (state_q == IDLE && input_request_i) begin
            len_q  <= cfg_len_q;
            wid_q  <= cfg_wid_q;
            base_q <= cfg_base_q;
            x1_q   <= input_addr_x_i_1;
            y1_q   <= input_addr_y_i_1;
            x2_q   <= input_addr_x_i_2;
            y2_q   <= input_addr_y_i_2;
        end
    end

    // slot tag follows the SRAM's one-cycle read latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld_q  <= 1'b0;
            rd_pad_q  <= 1'b0;
            rd_slot_q <= '0;
        end else begin
            rd_vld_q  <= run;
            rd_pad_q  <= pad;
            rd_slot_q <= slot;
        end
    end

    always_comb begin
        stage_n = stage_q;
        if (rd_vld_q)
            stage_n[rd_slot_q] = rd_pad_q ? '0 : mem_rdata_i;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < TILE_SLOTS; i++)
                stage_q[i] <= '0;
        end else begin
            stage_q <= stage_n;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            input_data_o_1 <= '0;
            input_data_o_2 <= '0;
        end else if (state_q == DRAIN) begin
            for (int r = 0; r < TILE_DIM; r++) begin
                for (int c = 0; c < TILE_DIM; c++) begin
                    input_data_o_1[r][c] <= stage_n[6*r + c];
                    input_data_o_2[r][c] <= stage_n[36 + 6*r + c];
                end
            end
        end
    end

endmodule
